// File: rtl/pixl_transmit_if.sv
// Line-word handshake between the line source and pixl_transmit.
// A word moves on any rising pixl_clk edge where line_valid && line_ready.
// master = line source, slave = transmitter.
interface pixl_transmit_if #(
  parameter int DATA_WIDTH = 21,
  parameter int LINE_BITS  = 25
);
  logic [(DATA_WIDTH-1)*LINE_BITS-1:0] line_data;
  logic                                line_sof;
  logic                                line_valid;
  logic                                line_ready;

  modport master (output line_data, output line_sof, output line_valid, input line_ready);
  modport slave  (input line_data, input line_sof, input line_valid, output line_ready);
endinterface

// File: rtl/pixl_transmit.sv
// Pixel-link line transmitter: 500-bit line words onto 20 data lanes plus a frame lane, LSB first, gap-free.
// Latency: word accepted at edge E puts its bit 0 on pixl_bit after E and its bit 24 after edge E+24.
// Backpressure: line_ready only on the last bit of a line (or in IDLE); a missing word is sent as an all-zero line.
// Optional build macro PIXL_TX_TESTPAT_EN adds a test_mode input that generates counting-pattern lines internally.
module pixl_transmit #(
  parameter int DATA_WIDTH = 21,
  parameter int LINE_BITS  = 25,
  parameter int LINES      = 500
) (
  input  logic                  pixl_clk,
  input  logic                  rstn,
  input  logic                  tx_en,
`ifdef PIXL_TX_TESTPAT_EN
  input  logic                  test_mode,
`endif
  pixl_transmit_if.slave        line_if,
  output logic [DATA_WIDTH-1:0] pixl_bit,
  output logic [8:0]            line_cnt,
  output logic [15:0]           frame_cnt,
  output logic                  underrun,
  output logic                  sync_err
);

  localparam int NLANE = DATA_WIDTH - 1;
  localparam int WORD  = NLANE * LINE_BITS;
  localparam int BCW   = $clog2(LINE_BITS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WORD-1:0]  sr_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [8:0]       line_cnt_q;
  logic [15:0]      frame_cnt_q;
  logic             underrun_q, sync_err_q;

  logic             boundary, last_line, tm, rdy;
  logic [8:0]       line_nxt;
  logic             ld, frame_inc, sync_err_d, underrun_d;
  logic [WORD-1:0]  ld_word;
  logic [8:0]       ld_line;

  // Bit 0 of every lane, i.e. the bits that go on the pins next.
  function automatic logic [NLANE-1:0] lane_lsb(input logic [WORD-1:0] w);
    logic [NLANE-1:0] r;
    r = '0;
    for (int i = 0; i < NLANE; i++) r[i] = w[i*LINE_BITS];
    return r;
  endfunction

  // Every lane shifted right by one independently, zero filled at the top.
  function automatic logic [WORD-1:0] lane_shift(input logic [WORD-1:0] w);
    logic [WORD-1:0] r;
    r = '0;
    for (int i = 0; i < NLANE; i++)
      r[i*LINE_BITS +: LINE_BITS] = {1'b0, w[i*LINE_BITS+1 +: LINE_BITS-1]};
    return r;
  endfunction

`ifdef PIXL_TX_TESTPAT_EN
  // Counting pattern: lane i of line ln carries ln*NLANE + i, truncated to a lane.
  function automatic logic [WORD-1:0] pattern(input logic [8:0] ln);
    logic [WORD-1:0] r;
    r = '0;
    for (int i = 0; i < NLANE; i++)
      r[i*LINE_BITS +: LINE_BITS] = LINE_BITS'(32'(ln) * 32'(NLANE) + 32'(i));
    return r;
  endfunction

  assign tm = test_mode;
`else
  assign tm = 1'b0;
`endif

  assign boundary  = (bit_cnt_q == BCW'(LINE_BITS - 1));
  assign last_line = (line_cnt_q == 9'(LINES - 1));
  assign line_nxt  = last_line ? 9'd0 : line_cnt_q + 9'd1;

  // State register.
  always_ff @(posedge pixl_clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, handshake and per-line load decisions.
  always_comb begin
    state_d    = state_q;
    rdy        = 1'b0;
    ld         = 1'b0;
    ld_word    = line_if.line_data;
    ld_line    = 9'd0;
    frame_inc  = 1'b0;
    sync_err_d = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = tx_en && !tm;
`ifdef PIXL_TX_TESTPAT_EN
        if (tm && tx_en) begin
          state_d   = RUN;
          ld        = 1'b1;
          ld_word   = pattern(9'd0);
          frame_inc = 1'b1;
        end else
`endif
        if (rdy && line_if.line_valid) begin
          // Only a start-of-frame word may open a frame; anything else is dropped.
          if (line_if.line_sof) begin
            state_d   = RUN;
            ld        = 1'b1;
            frame_inc = 1'b1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (boundary) begin
          if (last_line && !tx_en) begin
            state_d = IDLE;
          end else begin
            rdy       = !tm;
            ld        = 1'b1;
            ld_line   = line_nxt;
            frame_inc = last_line;
`ifdef PIXL_TX_TESTPAT_EN
            if (tm) ld_word = pattern(line_nxt); else
`endif
            if (line_if.line_valid) begin
              // Misplaced sof is flagged but the word still goes out as the counted line.
              sync_err_d = line_if.line_sof != (line_nxt == 9'd0);
            end else begin
              ld_word    = '0;
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, pin flops and counters.
  always_ff @(posedge pixl_clk or negedge rstn) begin
    if (!rstn) begin
      pixl_bit    <= '0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (ld) begin
        pixl_bit   <= {ld_line == 9'd0, lane_lsb(ld_word)};
        sr_q       <= lane_shift(ld_word);
        bit_cnt_q  <= '0;
        line_cnt_q <= ld_line;
      end else if (state_q == RUN && state_d == RUN) begin
        pixl_bit  <= {1'b0, lane_lsb(sr_q)};
        sr_q      <= lane_shift(sr_q);
        bit_cnt_q <= bit_cnt_q + BCW'(1);
      end else begin
        pixl_bit   <= '0;
        sr_q       <= '0;
        bit_cnt_q  <= '0;
        line_cnt_q <= '0;
      end
    end
  end

  // Ready is forced low while reset is held so every output drops with rstn.
  assign line_if.line_ready = rdy && rstn;
  assign line_cnt           = line_cnt_q;
  assign frame_cnt          = frame_cnt_q;
  assign underrun           = underrun_q;
  assign sync_err           = sync_err_q;

endmodule

// File: doc/pixl_transmit.md
Name: pixl_transmit

Overview:
Source-synchronous line transmitter for the pixel link. Takes 500-bit line words over a valid/ready handshake and serialises each across 20 data lanes, 25 bits per lane, LSB first. The MSB lane carries a one-cycle frame marker on bit 0 of line 0. Frames are 500 lines and the bit stream is gap-free; it feeds the board-level OBUFDS pins driven alongside the forwarded pixl_clk.

Parameters:
DATA_WIDTH, 21, total lanes; lane DATA_WIDTH-1 is the frame lane, the rest are data lanes
LINE_BITS, 25, bits per lane per line
LINES, 500, lines per frame

Ports:
pixl_clk  input  1  sole clock; all logic on rising edge
rstn  input  1  asynchronous active-low reset
tx_en  input  1  synchronous level; start/continue transmission
line_data  input  (DATA_WIDTH-1)*LINE_BITS  line word; lane i = bits [i*LINE_BITS +: LINE_BITS]
line_sof  input  1  qualifies line_data as line 0 of a frame
line_valid  input  1  line_data/line_sof valid
line_ready  output  1  block accepts a word on valid&&ready edge
pixl_bit  output  DATA_WIDTH  registered lane outputs (IOB flops); [DATA_WIDTH-1] = frame
line_cnt  output  9  index of line currently on pins
frame_cnt  output  16  frames started, wraps at 65535->0
underrun  output  1  one-cycle pulse: line slot with no valid word
sync_err  output  1  one-cycle pulse: sof misplaced

Behaviour:
- Reset, async, immediate: state IDLE; pixl_bit=0, line_ready=0, line_cnt=0, frame_cnt=0, underrun=0, sync_err=0; shift regs cleared.
- bit_cnt = index (0..LINE_BITS-1) of the bit currently on the data lanes.
- IDLE:
  - pixl_bit=0; line_ready=tx_en.
  - Accept with line_sof=1: load shift regs, go RUN, bit_cnt=0, line_cnt=0, frame_cnt+1.
  - Accept with line_sof=0: drop the word, pulse sync_err, stay IDLE.
- RUN:
  - Each cycle, data lane i presents lane-i bit bit_cnt; shift right by one per cycle.
  - Frame lane =1 only when line_cnt==0 && bit_cnt==0; else 0.
  - line_ready=1 only while bit_cnt==LINE_BITS-1 and (line_cnt!=LINES-1 || tx_en).
- Latency: word accepted at edge E; its bit 0 is on pixl_bit the cycle after E, bit 24 at E+25 cycles. No idle cycles between lines.
- Line boundary (edge ending bit_cnt==LINE_BITS-1):
  - bit_cnt->0; line_cnt+1, wrapping LINES-1 -> 0. On the wrap, frame_cnt+1.
  - valid&&ready: load the new word.
  - sof=1 with the next line_cnt!=0, or sof=0 with the next line_cnt==0: pulse sync_err, still transmit the word as the counted line. Counters are never realigned.
  - ready&&!valid: transmit an all-zero data line, pulse underrun, counters advance normally. Frame marker is still sent if that line is line 0.
- Stop: tx_en is sampled only at the line_cnt==LINES-1 boundary. If tx_en=0 there, no word is accepted, and the next cycle is IDLE with pins 0. Deasserting tx_en mid-frame completes the frame.
- Reset mid-frame: pins drop to 0 asynchronously. After release, restart from IDLE only; the receiver re-locks on the next frame marker.

Optional Feature:
PIXL_TX_TESTPAT_EN
- Defined: adds input test_mode (1 bit, synchronous, honoured only at line boundaries and in IDLE). When test_mode=1:
  - line_ready is held 0 and underrun never pulses.
  - Each line is generated internally: lane i = zero-extended (line_cnt*20+i) mod 2^25.
  - In IDLE, tx_en=1 starts RUN directly at line 0.
- Undefined: no test_mode port; behaviour exactly as above.

Test Plan:
- Reset release, tx_en=1, line 0 word lane0=25'h1, lane19=25'h1555555, sof=1 -> frame lane high exactly one cycle; lane0 emits 1 then 24 zeros; lane19 emits alternating bits starting with 1; frame_cnt=1.
- Stream 1000 valid lines, sof on every 500th -> frame marker every 12500 cycles; line_cnt wraps 499->0; frame_cnt 1->2->3; no underrun or sync_err.
- Drop valid for line 7 -> lines 7 all-zero, single underrun pulse, line 8 emitted on schedule at cycle offset 200.
- sof=1 on line 3 -> sync_err pulse, data sent as line 3, no frame marker.
- tx_en=0 at line 100 -> frame completes through line 499, then pixl_bit=0 and line_ready stays 0; re-enable with sof -> new frame marker.
- rstn low at line 250, bit 12 -> all outputs 0 asynchronously; after release, IDLE with line_ready=tx_en.
